// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the push-button / slide-switch input conditioner.
package input_conditioner_pkg;

  localparam int TICK_DIV_DEF     = 50000;
  localparam int STABLE_TICKS_DEF = 10;
  localparam int N_BTN_DEF        = 4;
  localparam int N_SW_DEF         = 10;

  // Counter width for a modulus n; never narrower than one bit so n == 1 still elaborates.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One conditioner channel: 2-flop synchroniser, tick-driven stability counter and
// the accepted clean level.
module debounce_chan
  import input_conditioner_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic clean
);

  localparam int             CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

  logic          meta;
  logic          s;
  logic [CW-1:0] c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_LEVEL;
      s    <= RESET_LEVEL;
    end else begin
      meta <= raw;
      s    <= meta;
    end
  end

  // Any cycle where the input agrees with the accepted level discards progress,
  // so a bounce shorter than the window can never be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c     <= '0;
      clean <= RESET_LEVEL;
    end else if (s == clean) begin
      c <= '0;
    end else if (tick) begin
      if (c >= LAST) begin
        clean <= s;
        c     <= '0;
      end else begin
        c <= c + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces the board buttons and switches, and turns button level changes into
// press/release pulses plus a sticky press flag for firmware.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int N_SW         = N_SW_DEF,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] btn_raw_n,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_clean_n,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] evt_pending,
  input  logic [N_BTN-1:0] evt_clr
);

  localparam int            PW         = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    presc;
  logic             tick;
  logic [N_BTN-1:0] btn_level;
  logic [N_SW-1:0]  sw_level;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_chan #(
        .STABLE_TICKS (STABLE_TICKS),
        .RESET_LEVEL  (1'b1)
      ) u_chan (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .tick  (tick),
        .raw   (btn_raw_n[gi]),
        .clean (btn_level[gi])
      );
    end
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_chan #(
        .STABLE_TICKS (STABLE_TICKS),
        .RESET_LEVEL  (1'b0)
      ) u_chan (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .tick  (tick),
        .raw   (sw_raw[gi]),
        .clean (sw_level[gi])
      );
    end
  endgenerate

  // Output stage: the registered levels and the edge pulses come from the same
  // comparison, so a pulse is high in exactly the cycle its level changes.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      btn_clean_n <= '1;
      sw_clean    <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      evt_pending <= '0;
    end else begin
      btn_clean_n <= btn_level;
      sw_clean    <= sw_level;
      btn_press   <= btn_clean_n & ~btn_level;
      btn_release <= ~btn_clean_n & btn_level;
      // A press arriving with a clear keeps the flag set.
      evt_pending <= btn_press | (evt_pending & ~evt_clr);
    end
  end

endmodule
